// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the five-stage pipeline control path.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    // resultSrc encodings driven by the decoder
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // E-stage operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // data-memory wait FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ERR  = 2'b10
    } wait_state_t;

    // M beats W; a write to x0 never forwards, so a source of x0 always reads the register file
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory wait handshake: freezes the pipeline while an access is outstanding, aborts on timeout.
// Latency: dmemReq/memStall combinational from state and inputs; busErr registered, set on entry to ERR.
// Backpressure: memStall=1 while the request is unacknowledged; after TIMEOUT unacked cycles one ERR cycle releases it.
module dmem_wait_fsm
    import riscv_pipe_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic memAccessM,
    input  logic dmemAck,
    output logic dmemReq,
    output logic memStall,
    output logic busErr
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wait_state_t      state;
    logic [CNT_W-1:0] waitCnt;

    // state, wait counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            waitCnt <= '0;
            busErr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memAccessM && !dmemAck) begin
                        state   <= S_WAIT;
                        waitCnt <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmemAck) begin
                        state   <= S_IDLE;
                        waitCnt <= '0;
                    end else if (waitCnt == CNT_LAST) begin
                        // flag the error as the abort cycle starts so it is visible during ERR
                        state   <= S_ERR;
                        waitCnt <= '0;
                        busErr  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    // any late ack here is dropped; the pipeline advances as if the access completed
                    state  <= S_IDLE;
                    busErr <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    // request decode; gated by rst so a reset mid-wait drops the request immediately
    always_comb begin
        dmemReq = 1'b0;
        case (state)
            S_IDLE:  dmemReq = memAccessM;
            S_WAIT:  dmemReq = 1'b1;
            default: dmemReq = 1'b0;
        endcase
        dmemReq  = dmemReq & ~rst;
        memStall = dmemReq & ~dmemAck;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward control for the five-stage core; optional perf counters under HAZARD_PERF_EN.
// Latency: hazard, flush and forward outputs combinational; busErr and perf counters registered.
// Backpressure: memory wait freezes all five stages and defers flushes until the release cycle.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic [1:0]        resultSrcE,
    input  logic              PCSrcE,
    input  logic [4:0]        RdM,
    input  logic              regWriteM,
    input  logic              memAccessM,
    input  logic [4:0]        RdW,
    input  logic              regWriteW,
    input  logic              dmemAck,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              dmemReq,
    output logic              busErr,
    output logic [PERF_W-1:0] perfStall,
    output logic [PERF_W-1:0] perfFlush,
    output logic [PERF_W-1:0] perfMemWait
);
    import riscv_pipe_pkg::*;

    logic memStall;
    logic lwStall;

    dmem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .memAccessM (memAccessM),
        .dmemAck    (dmemAck),
        .dmemReq    (dmemReq),
        .memStall   (memStall),
        .busErr     (busErr)
    );

    // load-use detection, stall/flush combination and operand forwarding
    always_comb begin
        lwStall   = (resultSrcE == RES_MEM) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        forwardAE = fwd_sel(Rs1E, RdM, regWriteM, RdW, regWriteW);
        forwardBE = fwd_sel(Rs2E, RdM, regWriteM, RdW, regWriteW);
        // a memory wait freezes everything; a pending redirect stays in E until release
        stallF    = lwStall | memStall;
        stallD    = lwStall | memStall;
        stallE    = memStall;
        stallM    = memStall;
        stallW    = memStall;
        flushD    = PCSrcE & ~memStall;
        flushE    = (lwStall | PCSrcE) & ~memStall;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic [PERF_W-1:0] memwait_cnt;

    // free-running event counters, wrapping naturally at 2^PERF_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (stallF)
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (flushD | flushE)
                flush_cnt <= flush_cnt + PERF_W'(1);
            if (memStall)
                memwait_cnt <= memwait_cnt + PERF_W'(1);
        end
    end

    assign perfStall   = stall_cnt;
    assign perfFlush   = flush_cnt;
    assign perfMemWait = memwait_cnt;
`else
    assign perfStall   = '0;
    assign perfFlush   = '0;
    assign perfMemWait = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl built with TIMEOUT=4; expected output vectors are queued as stimulus is applied.
// Latency: outputs sampled on the falling edge after inputs change just past the rising edge.
// Backpressure: n/a.
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    localparam int TO     = 4;
    localparam int PERF_W = 32;

    logic              clk;
    logic              rst;
    logic [4:0]        Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]        resultSrcE;
    logic              PCSrcE, regWriteM, memAccessM, regWriteW, dmemAck;
    logic              stallF, stallD, stallE, stallM, stallW, flushD, flushE;
    logic [1:0]        forwardAE, forwardBE;
    logic              dmemReq, busErr;
    logic [PERF_W-1:0] perfStall, perfFlush, perfMemWait;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pcs;
        logic [4:0] rdm;
        logic       rwm;
        logic       mam;
        logic [4:0] rdw;
        logic       rww;
        logic       ack;
    } stim_t;

    hazard_ctrl #(.TIMEOUT(TO), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .regWriteM(regWriteM), .memAccessM(memAccessM),
        .RdW(RdW), .regWriteW(regWriteW), .dmemAck(dmemAck),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .dmemReq(dmemReq), .busErr(busErr),
        .perfStall(perfStall), .perfFlush(perfFlush), .perfMemWait(perfMemWait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic stim_t mkst(input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                                   input int rde, input logic [1:0] rsrc, input int pcs,
                                   input int rdm, input int rwm, input int mam,
                                   input int rdw, input int rww, input int ack);
        stim_t s;
        s.rs1d = 5'(rs1d); s.rs2d = 5'(rs2d); s.rs1e = 5'(rs1e); s.rs2e = 5'(rs2e);
        s.rde  = 5'(rde);  s.rsrc = rsrc;     s.pcs  = 1'(pcs);
        s.rdm  = 5'(rdm);  s.rwm  = 1'(rwm);  s.mam  = 1'(mam);
        s.rdw  = 5'(rdw);  s.rww  = 1'(rww);  s.ack  = 1'(ack);
        return s;
    endfunction

    // expected vector: stallF/D share stfd, stallE/M/W share stemw
    function automatic logic [12:0] mk(input int stfd, input int stemw, input int fld, input int fle,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input int req, input int err);
        return {1'(stfd), 1'(stfd), 1'(stemw), 1'(stemw), 1'(stemw),
                1'(fld), 1'(fle), fa, fb, 1'(req), 1'(err)};
    endfunction

    function automatic logic [12:0] obs();
        return {stallF, stallD, stallE, stallM, stallW, flushD, flushE,
                forwardAE, forwardBE, dmemReq, busErr};
    endfunction

    task automatic apply(input stim_t s);
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
        resultSrcE = s.rsrc; PCSrcE = s.pcs; RdM = s.rdm; regWriteM = s.rwm;
        memAccessM = s.mam; RdW = s.rdw; regWriteW = s.rww; dmemAck = s.ack;
    endtask

    task automatic test_reset();
        logic [12:0] got, want;
        apply(mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0));
        rst = 1'b1;
        exp_q.push_back(mk(0,0,0,0,FWD_RF,FWD_RF,0,0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_outputs got=%b want=%b", got, want); end
        checks++;
        if (perfStall !== '0) begin failures++; $display("FAIL reset_perfStall got=%0d want=0", perfStall); end
        checks++;
        if (perfFlush !== '0) begin failures++; $display("FAIL reset_perfFlush got=%0d want=0", perfFlush); end
        checks++;
        if (perfMemWait !== '0) begin failures++; $display("FAIL reset_perfMemWait got=%0d want=0", perfMemWait); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mk(0,0,0,0,FWD_RF,FWD_RF,0,0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_release got=%b want=%b", got, want); end
    endtask

    task automatic test_forward();
        stim_t st[5]; logic [12:0] ex[5]; logic [12:0] got, want;
        st[0] = mkst(0,0,5,0,0,RES_ALU,0,5,1,0,5,1,0); ex[0] = mk(0,0,0,0,FWD_M, FWD_RF,0,0);
        st[1] = mkst(0,0,5,0,0,RES_ALU,0,5,0,0,5,1,0); ex[1] = mk(0,0,0,0,FWD_W, FWD_RF,0,0);
        st[2] = mkst(0,0,0,9,0,RES_ALU,0,0,1,0,9,1,0); ex[2] = mk(0,0,0,0,FWD_RF,FWD_W, 0,0);
        st[3] = mkst(0,0,3,3,0,RES_ALU,0,3,1,0,3,0,0); ex[3] = mk(0,0,0,0,FWD_M, FWD_M, 0,0);
        st[4] = mkst(0,0,4,6,0,RES_ALU,0,4,1,0,6,1,0); ex[4] = mk(0,0,0,0,FWD_M, FWD_W, 0,0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL forward[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_load_use();
        stim_t st[5]; logic [12:0] ex[5]; logic [12:0] got, want;
        st[0] = mkst(0,7,0,0,7,RES_MEM,0,0,0,0,0,0,0); ex[0] = mk(1,0,0,1,FWD_RF,FWD_RF,0,0);
        st[1] = mkst(0,7,0,0,0,RES_MEM,0,0,0,0,0,0,0); ex[1] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[2] = mkst(0,0,0,0,0,RES_MEM,0,0,0,0,0,0,0); ex[2] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[3] = mkst(7,0,0,0,7,RES_ALU,0,0,0,0,0,0,0); ex[3] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[4] = mkst(7,0,0,0,7,RES_MEM,0,0,0,0,0,0,0); ex[4] = mk(1,0,0,1,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_branch();
        stim_t st[2]; logic [12:0] ex[2]; logic [12:0] got, want;
        st[0] = mkst(0,0,0,0,0,RES_ALU,1,0,0,0,0,0,0); ex[0] = mk(0,0,1,1,FWD_RF,FWD_RF,0,0);
        st[1] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[1] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[7]; logic [12:0] ex[7]; logic [12:0] got, want;
        // three unacked cycles, ack on the fourth, then a zero-wait access, then idle
        for (int i = 0; i < 3; i++) begin
            st[i] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[i] = mk(1,1,0,0,FWD_RF,FWD_RF,1,0);
        end
        st[3] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[3] = mk(0,0,0,0,FWD_RF,FWD_RF,1,0);
        st[4] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[4] = mk(0,0,0,0,FWD_RF,FWD_RF,1,0);
        st[5] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[5] = mk(0,0,0,0,FWD_RF,FWD_RF,1,0);
        st[6] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[6] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL mem_wait[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_mem_wait_branch();
        stim_t st[4]; logic [12:0] ex[4]; logic [12:0] got, want;
        st[0] = mkst(0,0,0,0,0,RES_ALU,1,0,0,1,0,0,0); ex[0] = mk(1,1,0,0,FWD_RF,FWD_RF,1,0);
        st[1] = mkst(0,0,0,0,0,RES_ALU,1,0,0,1,0,0,0); ex[1] = mk(1,1,0,0,FWD_RF,FWD_RF,1,0);
        st[2] = mkst(0,0,0,0,0,RES_ALU,1,0,0,1,0,0,1); ex[2] = mk(0,0,1,1,FWD_RF,FWD_RF,1,0);
        st[3] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[3] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL mem_branch[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_perf();
        stim_t st[7]; logic [12:0] ex[7]; logic [12:0] got, want;
        int exp_stall, exp_flush, exp_mw;
        @(posedge clk); #1;
        rst = 1'b1;
        apply(mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        rst = 1'b0;
        st[0] = mkst(7,0,0,0,7,RES_MEM,0,0,0,0,0,0,0); ex[0] = mk(1,0,0,1,FWD_RF,FWD_RF,0,0);
        st[1] = mkst(0,3,0,0,3,RES_MEM,0,0,0,0,0,0,0); ex[1] = mk(1,0,0,1,FWD_RF,FWD_RF,0,0);
        for (int i = 2; i < 5; i++) begin
            st[i] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[i] = mk(1,1,0,0,FWD_RF,FWD_RF,1,0);
        end
        st[5] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[5] = mk(0,0,0,0,FWD_RF,FWD_RF,1,0);
        st[6] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[6] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL perf_seq[%0d] got=%b want=%b", i, got, want); end
        end
`ifdef HAZARD_PERF_EN
        exp_stall = 5; exp_flush = 2; exp_mw = 3;
`else
        exp_stall = 0; exp_flush = 0; exp_mw = 0;
`endif
        checks++;
        if (perfStall !== PERF_W'(exp_stall)) begin
            failures++; $display("FAIL perfStall got=%0d want=%0d", perfStall, exp_stall);
        end
        checks++;
        if (perfFlush !== PERF_W'(exp_flush)) begin
            failures++; $display("FAIL perfFlush got=%0d want=%0d", perfFlush, exp_flush);
        end
        checks++;
        if (perfMemWait !== PERF_W'(exp_mw)) begin
            failures++; $display("FAIL perfMemWait got=%0d want=%0d", perfMemWait, exp_mw);
        end
    endtask

    task automatic test_timeout();
        stim_t st[7]; logic [12:0] ex[7]; logic [12:0] got, want;
        for (int i = 0; i < TO; i++) begin
            st[i] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[i] = mk(1,1,0,0,FWD_RF,FWD_RF,1,0);
        end
        // abort cycle: a late ack must not matter, request is withdrawn and the error is visible
        st[4] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[4] = mk(0,0,0,0,FWD_RF,FWD_RF,0,1);
        st[5] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[5] = mk(0,0,0,0,FWD_RF,FWD_RF,0,1);
        st[6] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[6] = mk(0,0,0,0,FWD_RF,FWD_RF,0,1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL timeout[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[7]; logic [12:0] ex[7]; logic [12:0] got, want;
        st[0] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[0] = mk(1,1,0,0,FWD_RF,FWD_RF,1,1);
        st[1] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[1] = mk(1,1,0,0,FWD_RF,FWD_RF,1,1);
        st[2] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,0); ex[2] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[3] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[3] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[4] = mkst(0,0,0,0,0,RES_ALU,0,0,0,1,0,0,1); ex[4] = mk(0,0,0,0,FWD_RF,FWD_RF,1,0);
        st[5] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[5] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        st[6] = mkst(0,0,0,0,0,RES_ALU,0,0,0,0,0,0,0); ex[6] = mk(0,0,0,0,FWD_RF,FWD_RF,0,0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            // reset lands between edges on step 2, with the request still asserted
            rst = (i == 2) ? 1'b1 : 1'b0;
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL reset_mid_wait[%0d] got=%b want=%b", i, got, want); end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mem_wait_branch();
        test_perf();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
